irq_controller: RTL

Device-side end of the processor's vectored-interrupt handshake. It collects completion events from four peripherals, prioritises them, raises `interrupt` toward the MIPS core, and presents the vector address of the granted source on `int_addr`. It retires the request on `int_ack` and holds that source in service until software writes end-of-interrupt. It sits between the peripherals and the `mips` top, and also exposes a small word-addressed register window for software.

---
 rtl/irq_pkg.sv | 26 ++
 rtl/irq_edge_latch.sv | 32 +++
 rtl/irq_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the vectored interrupt controller.
// Holds the FSM state encoding, register window offsets and the priority helper.
package irq_pkg;

    localparam int NUM_SRC = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam logic [1:0] MASK = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] STAT = 2'd2;
    localparam logic [1:0] EOI  = 2'd3;

    // Index of the lowest set bit; bit 0 has the highest priority.
    function automatic logic [1:0] lowest_set(input logic [NUM_SRC-1:0] v);
        lowest_set = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 2'(i);
        end
    endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector on the peripheral done levels feeding a sticky pending
// register; a new edge always wins over a clear of the same bit.
module irq_edge_latch
    import irq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] done_i,
    input  logic [NUM_SRC-1:0] clr_i,
    output logic [NUM_SRC-1:0] pending_o
);

    logic [NUM_SRC-1:0] done_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] evt;

    assign evt       = done_i & ~done_q;
    assign pending_d = (pending_q & ~clr_i) | evt;
    assign pending_o = pending_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q    <= '0;
            pending_q <= '0;
        end else begin
            done_q    <= done_i;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller: arbitrates pending peripheral events, requests
// the CPU, and holds the granted source in service until software writes EOI.
module irq_controller
    import irq_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_SRC-1:0]  done,
    input  logic                int_ack,
    output logic                interrupt,
    output logic [31:0]         int_addr,
    output logic [1:0]          int_id,
    input  logic                we,
    input  logic [1:0]          a,
    input  logic [31:0]         wd,
    output logic [31:0]         rd
);

    irq_state_e         state_q, state_d;
    logic [1:0]         int_id_q, int_id_d;
    logic [31:0]        int_addr_q, int_addr_d;
    logic               interrupt_q, interrupt_d;
    logic               in_service_q, in_service_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] ack_clr;
    logic               wr_mask, wr_pend, wr_eoi;
    logic               ack_taken;

    assign wr_mask   = we && (a == MASK);
    assign wr_pend   = we && (a == PEND);
    assign wr_eoi    = we && (a == EOI);
    assign ack_taken = (state_q == REQ) && int_ack;
    assign req       = pending & mask_q;

    // Ack retires the granted source; software W1C may clear any bits.
    assign ack_clr = ack_taken ? (NUM_SRC'(1) << int_id_q) : '0;
    assign clr     = ack_clr | (wr_pend ? wd[NUM_SRC-1:0] : '0);

    irq_edge_latch u_edge_latch (
        .clk       (clk),
        .reset     (reset),
        .done_i    (done),
        .clr_i     (clr),
        .pending_o (pending)
    );

    always_comb begin
        state_d      = state_q;
        int_id_d     = int_id_q;
        int_addr_d   = int_addr_q;
        interrupt_d  = interrupt_q;
        in_service_d = in_service_q;
        mask_d       = wr_mask ? wd[NUM_SRC-1:0] : mask_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    int_id_d    = lowest_set(req);
                    int_addr_d  = VEC_BASE + VEC_STRIDE * {30'b0, lowest_set(req)};
                    interrupt_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    in_service_d = 1'b1;
                    interrupt_d  = 1'b0;
                    state_d      = SERVICE;
                end
            end
            SERVICE: begin
                interrupt_d = 1'b0;
                if (wr_eoi) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                interrupt_d  = 1'b0;
                in_service_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            int_id_q     <= '0;
            int_addr_q   <= VEC_BASE;
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b0;
            mask_q       <= '1;
        end else begin
            state_q      <= state_d;
            int_id_q     <= int_id_d;
            int_addr_q   <= int_addr_d;
            interrupt_q  <= interrupt_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
        end
    end

    always_comb begin
        rd = '0;
        case (a)
            MASK: rd[NUM_SRC-1:0] = mask_q;
            PEND: rd[NUM_SRC-1:0] = pending;
            STAT: rd[5:0]         = {state_q, in_service_q, 1'b0, int_id_q};
            default: rd = '0;
        endcase
    end

    assign interrupt = interrupt_q;
    assign int_addr  = int_addr_q;
    assign int_id    = int_id_q;

endmodule
